// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - shared MU0 opcode, sequencer state and phase definitions
package mu0_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_STO = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_JMP = 4'b0100,
    OP_JGE = 4'b0101,
    OP_JNE = 4'b0110,
    OP_STP = 4'b0111,
    OP_OUT = 4'b1000
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH_INSTR_ADDR = 3'b000,
    FETCH_INSTR_DATA = 3'b001,
    EXEC_ADDR        = 3'b010,
    EXEC_DATA        = 3'b011,
    HALTED           = 3'b100
  } state_t;

  localparam logic [1:0] PH_FETCH_ADDR = 2'd0;
  localparam logic [1:0] PH_FETCH_DATA = 2'd1;
  localparam logic [1:0] PH_EXEC_ADDR  = 2'd2;
  localparam logic [1:0] PH_EXEC_DATA  = 2'd3;

  // Opcodes whose operand is fetched from memory during the execute phases.
  function automatic logic op_reads_mem(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mu0_alu.sv
// rtl/mu0_alu.sv - combinational MU0 execute: next ACC, branch decision, halt/illegal decode
module mu0_alu
  import mu0_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic [DATA_W-1:0] acc_next_o,
  output logic              jump_taken_o,
  output logic              is_halt_o,
  output logic              is_illegal_o
);

  always_comb begin
    acc_next_o   = acc_i;
    jump_taken_o = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode_i)
      OP_LDA: acc_next_o = operand_i;
      OP_ADD: acc_next_o = acc_i + operand_i;
      OP_SUB: acc_next_o = acc_i - operand_i;
      OP_JMP: jump_taken_o = 1'b1;
      OP_JGE: jump_taken_o = ~acc_i[DATA_W-1];
      OP_JNE: jump_taken_o = |acc_i;
      OP_STP: is_halt_o = 1'b1;
      OP_STO, OP_OUT: ;
      default: begin
        is_halt_o    = 1'b1;
        is_illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mu0_exec_responder.sv
// rtl/mu0_exec_responder.sv - MU0 datapath: PC/IR/ACC, memory master and OUT port
module mu0_exec_responder
  import mu0_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic [1:0]        flag,
  output logic [2:0]        get_status,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              illegal
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  state_t            status_q, status_d;
  logic              out_valid_q, out_valid_d;
  logic              illegal_q, illegal_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand_s;
  logic [DATA_W-1:0] acc_next;
  logic              jump_taken;
  logic              is_halt;
  logic              is_illegal;

  assign opcode    = ir_q[DATA_W-1 -: 4];
  assign operand_s = ir_q[ADDR_W-1:0];

  mu0_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .opcode_i    (opcode),
    .acc_i       (acc_q),
    .operand_i   (readdata),
    .acc_next_o  (acc_next),
    .jump_taken_o(jump_taken),
    .is_halt_o   (is_halt),
    .is_illegal_o(is_illegal)
  );

  // Memory strobes follow the phase directly so STO commits at the end of phase 2.
  always_comb begin
    address   = pc_q;
    read      = 1'b0;
    write     = 1'b0;
    writedata = acc_q;
    if (running) begin
      case (flag)
        PH_FETCH_ADDR: read = 1'b1;
        PH_EXEC_ADDR: begin
          if (op_reads_mem(opcode)) begin
            address = operand_s;
            read    = 1'b1;
          end else if (opcode == OP_STO) begin
            address = operand_s;
            write   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    status_d    = status_q;
    out_valid_d = out_valid_q;
    illegal_d   = illegal_q;
    if (running) begin
      case (flag)
        PH_FETCH_ADDR: out_valid_d = 1'b0;
        PH_FETCH_DATA: begin
          ir_d        = readdata;
          pc_d        = pc_q + ADDR_W'(1);
          out_valid_d = 1'b0;
        end
        PH_EXEC_ADDR: begin
          if (jump_taken) pc_d = operand_s;
          // Once halted the status never returns to fetch until reset.
          status_d  = (status_q == HALTED || is_halt) ? HALTED : FETCH_INSTR_ADDR;
          illegal_d = illegal_q | is_illegal;
          if (opcode == OP_OUT) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
          end
        end
        PH_EXEC_DATA: begin
          acc_d       = acc_next;
          out_valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      status_q    <= FETCH_INSTR_ADDR;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign get_status = status_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_mu0_exec_responder.sv
// tb/tb_mu0_exec_responder.sv - scoreboard bench for the MU0 datapath
module tb_mu0_exec_responder;
  import mu0_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              running = 1'b0;
  logic [1:0]        flag = 2'd0;
  logic [2:0]        get_status;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              illegal;

  mu0_exec_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(12'h000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .running   (running),
    .flag      (flag),
    .get_status(get_status),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model plus a bench-side load port.
  logic [DATA_W-1:0] mem [0:4095];
  logic              ld_we = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;

  always @(posedge clk) begin
    if (read) readdata <= mem[address];
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (write) mem[address] <= writedata;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic missing(input string name);
    n_checks++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // Scoreboard queues
  logic [ADDR_W-1:0]        exp_fetch_q[$];
  logic [2:0]               exp_status_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_write_q[$];
  logic [DATA_W-1:0]        exp_out_q[$];

  logic [ADDR_W+DATA_W-1:0] e_w;
  logic [ADDR_W-1:0]        e_f;
  logic [2:0]               e_s;
  logic [DATA_W-1:0]        e_o;

  always @(negedge clk) begin
    if (write) begin
      check("rw_exclusive", {31'd0, read}, 32'd0);
      if (exp_write_q.size() == 0) missing("write");
      else begin
        e_w = exp_write_q.pop_front();
        check("write_addr", {20'd0, address}, {20'd0, e_w[ADDR_W+DATA_W-1:DATA_W]});
        check("write_data", {16'd0, writedata}, {16'd0, e_w[DATA_W-1:0]});
      end
    end
    if (!rst && running) begin
      if (flag == PH_FETCH_ADDR) begin
        if (exp_fetch_q.size() == 0) missing("fetch");
        else begin
          e_f = exp_fetch_q.pop_front();
          check("fetch_read", {31'd0, read}, 32'd1);
          check("fetch_addr", {20'd0, address}, {20'd0, e_f});
        end
      end
      if (flag == PH_EXEC_DATA) begin
        if (exp_status_q.size() == 0) missing("status");
        else begin
          e_s = exp_status_q.pop_front();
          check("status_ph3", {29'd0, get_status}, {29'd0, e_s});
        end
      end
    end
    if (out_valid) begin
      if (exp_out_q.size() == 0) missing("out");
      else begin
        e_o = exp_out_q.pop_front();
        check("out_data", {16'd0, out_data}, {16'd0, e_o});
        check("out_phase", {30'd0, flag}, {30'd0, PH_EXEC_DATA});
      end
    end
  end

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic step(input logic [1:0] ph);
    flag = ph;
    @(posedge clk); #1;
  endtask

  task automatic run_instr();
    for (int p = 0; p < 4; p++) step(2'(p));
  endtask

  task automatic run_to_halt(input int max_instr);
    int n;
    n = 0;
    running = 1'b1;
    while (get_status != 3'b100 && n < max_instr) begin
      run_instr();
      n++;
    end
    running = 1'b0;
    flag = 2'd0;
    check("halt_reached", {29'd0, get_status}, 32'h4);
  endtask

  task automatic do_reset();
    rst = 1'b1; running = 1'b0; flag = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // {address, word} image for the main program
  logic [ADDR_W+DATA_W-1:0] prog1 [0:29] = '{
    {12'h000, 16'h0005}, {12'h001, 16'h8000}, {12'h002, 16'h4010}, {12'h005, 16'h1234},
    {12'h010, 16'h0100}, {12'h011, 16'h2101}, {12'h012, 16'h8000}, {12'h013, 16'h3102},
    {12'h014, 16'h6040}, {12'h015, 16'h3102}, {12'h016, 16'h8000}, {12'h017, 16'h0103},
    {12'h018, 16'h1020}, {12'h019, 16'h8000}, {12'h01A, 16'h0104}, {12'h01B, 16'h5040},
    {12'h01C, 16'h6040}, {12'h040, 16'h0020}, {12'h041, 16'h2105}, {12'h042, 16'h8000},
    {12'h043, 16'h0106}, {12'h044, 16'h5050}, {12'h050, 16'h7000}, {12'h100, 16'hFFFF},
    {12'h101, 16'h0002}, {12'h102, 16'h0001}, {12'h103, 16'hBEEF}, {12'h104, 16'h8000},
    {12'h105, 16'h0011}, {12'h106, 16'h7FFF}
  };
  logic [ADDR_W-1:0] fetch1 [0:21] = '{
    12'h000, 12'h001, 12'h002, 12'h010, 12'h011, 12'h012, 12'h013, 12'h014,
    12'h015, 12'h016, 12'h017, 12'h018, 12'h019, 12'h01A, 12'h01B, 12'h01C,
    12'h040, 12'h041, 12'h042, 12'h043, 12'h044, 12'h050
  };
  logic [DATA_W-1:0] outs1 [0:4] = '{16'h1234, 16'h0001, 16'hFFFF, 16'hBEEF, 16'hBF00};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    check("rst_status", {29'd0, get_status}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("idle_read", {31'd0, read}, 32'd0);
    do_reset();

    // Main program: load, arithmetic wrap, store, OUT, branches, STP.
    for (int i = 0; i < 30; i++) poke(prog1[i][27:16], prog1[i][15:0]);
    for (int i = 0; i < 22; i++) begin
      exp_fetch_q.push_back(fetch1[i]);
      exp_status_q.push_back(i == 21 ? 3'b100 : 3'b000);
    end
    for (int i = 0; i < 5; i++) exp_out_q.push_back(outs1[i]);
    exp_write_q.push_back({12'h020, 16'hBEEF});
    run_to_halt(30);
    repeat (3) @(posedge clk);
    #1;
    check("stp_sticky", {29'd0, get_status}, 32'h4);
    check("stp_not_illegal", {31'd0, illegal}, 32'd0);

    // Illegal opcode 1111
    do_reset();
    poke(12'h000, 16'hF000);
    exp_fetch_q.push_back(12'h000);
    exp_status_q.push_back(3'b100);
    run_to_halt(4);
    repeat (3) @(posedge clk);
    #1;
    check("illegal_sticky", {31'd0, illegal}, 32'd1);
    check("illegal_status", {29'd0, get_status}, 32'h4);
    rst = 1'b1;
    #1;
    check("illegal_cleared", {31'd0, illegal}, 32'd0);
    check("status_cleared", {29'd0, get_status}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Async reset during phase 2 of STO
    poke(12'h000, 16'h0005);
    poke(12'h005, 16'h1234);
    poke(12'h001, 16'h1030);
    poke(12'h030, 16'h5555);
    exp_fetch_q.push_back(12'h000);
    exp_status_q.push_back(3'b000);
    exp_fetch_q.push_back(12'h001);
    running = 1'b1;
    run_instr();
    step(2'd0);
    step(2'd1);
    flag = 2'd2;
    #1;
    check("sto_write_before_rst", {31'd0, write}, 32'd1);
    rst = 1'b1;
    #1;
    check("sto_write_after_rst", {31'd0, write}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    running = 1'b0;
    flag = 2'd0;
    check("sto_abandoned", {16'd0, mem[12'h030]}, 32'h5555);

    // After reset: OUT shows ACC=0, then LDA, STO with a 5-cycle stall mid-instruction.
    poke(12'h000, 16'h8000);
    poke(12'h001, 16'h0005);
    poke(12'h002, 16'h1030);
    poke(12'h003, 16'h7000);
    for (int i = 0; i < 4; i++) begin
      exp_fetch_q.push_back(12'(i));
      exp_status_q.push_back(i == 3 ? 3'b100 : 3'b000);
    end
    exp_out_q.push_back(16'h0000);
    exp_write_q.push_back({12'h030, 16'h1234});
    running = 1'b1;
    run_instr();
    run_instr();
    step(2'd0);
    step(2'd1);
    running = 1'b0;
    flag = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_read", {31'd0, read}, 32'd0);
      check("stall_write", {31'd0, write}, 32'd0);
    end
    running = 1'b1;
    step(2'd2);
    step(2'd3);
    run_to_halt(2);
    check("stall_store_mem", {16'd0, mem[12'h030]}, 32'h1234);

    check("fetch_q_drained", exp_fetch_q.size(), 32'd0);
    check("status_q_drained", exp_status_q.size(), 32'd0);
    check("write_q_drained", exp_write_q.size(), 32'd0);
    check("out_q_drained", exp_out_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
